// File: rtl/ext_arith_unit.sv
// Iterative POWER / FACTORIAL unit: one multiply per clock, stalls the core while busy.
// Optional macro EXT_ARITH_SATURATE_EN: saturate to all-ones and stop on the first overflowing product.
module ext_arith_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   base_q, base_d;
    logic [W-1:0]   result_q, result_d;
    logic           op_q, op_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   mult_m;
    logic [2*W-1:0] product;
    logic           prod_ovf;

    // Factorial multiplies by the down-counter itself, power by the latched base.
    always_comb begin
        mult_m   = op_q ? cnt_q : base_q;
        product  = {{W{1'b0}}, acc_q} * {{W{1'b0}}, mult_m};
        prod_ovf = |product[2*W-1:W];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        result_d = result_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    base_d  = operand_a;
                    cnt_d   = operand_b;
                    acc_d   = W'(1);
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    acc_d = product[W-1:0];
                    cnt_d = cnt_q - W'(1);
                    if (prod_ovf) begin
                        ovf_d = 1'b1;
`ifdef EXT_ARITH_SATURATE_EN
                        // Clamp and zero the counter so the next edge finishes.
                        acc_d = '1;
                        cnt_d = '0;
`endif
                    end
                end else begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
            op_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            result_q <= result_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ext_arith_unit.sv
// Directed bench for ext_arith_unit: latency, results, overflow, back-to-back, ignored start, async reset.
module tb_ext_arith_unit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    ext_arith_unit #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts busy cycles until done is seen (bounded); returns at the negedge showing done.
    task automatic wait_done(input string tag, output int busy_cyc);
        busy_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    int bc;
    int done_count;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3^4 = 81, busy for 5 cycles
        start_op(1'b0, 16'd3, 16'd4);
        check("pow34_busy_now", busy, 1);
        operand_a = 16'd9;
        operand_b = 16'd9;
        wait_done("pow34", bc);
        check("pow34_busy_cycles", bc, 5);
        check("pow34_result", result, 81);
        check("pow34_ovf", overflow, 0);
        check("pow34_busy_in_done", busy, 0);
        @(negedge clk);
        check("pow34_done_pulse", done, 0);
        check("pow34_result_held", result, 81);

        // 5! = 120, then back-to-back 2^3 = 8
        start_op(1'b1, 16'd0, 16'd5);
        wait_done("fact5", bc);
        check("fact5_busy_cycles", bc, 6);
        check("fact5_result", result, 120);
        check("fact5_ovf", overflow, 0);
        start_op(1'b0, 16'd2, 16'd3);
        check("b2b_busy_no_gap", busy, 1);
        check("b2b_done_low", done, 0);
        check("b2b_result_kept", result, 120);
        wait_done("pow23", bc);
        check("pow23_busy_cycles", bc, 4);
        check("pow23_result", result, 8);
        @(negedge clk);

        // 9! overflows
        start_op(1'b1, 16'd0, 16'd9);
        wait_done("fact9", bc);
`ifdef EXT_ARITH_SATURATE_EN
        check("fact9_busy_cycles", bc, 8);
        check("fact9_result", result, 16'hFFFF);
`else
        check("fact9_busy_cycles", bc, 10);
        check("fact9_result", result, 35200);
`endif
        check("fact9_ovf", overflow, 1);
        @(negedge clk);
        check("fact9_ovf_held_idle", overflow, 1);

        // Boundaries
        start_op(1'b0, 16'd0, 16'd0);
        wait_done("pow00", bc);
        check("pow00_busy_cycles", bc, 1);
        check("pow00_result", result, 1);
        check("pow00_ovf_cleared", overflow, 0);
        @(negedge clk);
        start_op(1'b1, 16'd0, 16'd0);
        wait_done("fact0", bc);
        check("fact0_result", result, 1);
        @(negedge clk);
        start_op(1'b0, 16'd0, 16'd5);
        wait_done("pow05", bc);
        check("pow05_result", result, 0);
        check("pow05_ovf", overflow, 0);
        @(negedge clk);
        start_op(1'b0, 16'd2, 16'd16);
        wait_done("pow216", bc);
        check("pow216_busy_cycles", bc, 17);
        check("pow216_result", result, 0);
        check("pow216_ovf", overflow, 1);
        @(negedge clk);

        // Start during CALC is ignored
        start_op(1'b1, 16'd0, 16'd5);
        @(negedge clk);
        start_op(1'b0, 16'd7, 16'd2);
        wait_done("fact5_ign", bc);
        check("fact5_ign_result", result, 120);
        check("fact5_ign_ovf", overflow, 0);
        @(negedge clk);

        // Asynchronous reset mid-CALC
        start_op(1'b1, 16'd0, 16'd8);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        done_count = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_count++;
        end
        check("arst_no_done", done_count, 0);
        check("arst_idle_busy", busy, 0);

        // Recovery after reset
        start_op(1'b0, 16'd5, 16'd3);
        wait_done("pow53", bc);
        check("pow53_result", result, 125);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
